// File: rtl/cache_data_ram.sv
// ============================================================================
// cache_data_ram: synchronous cache data/tag RAM with a registered read, a
// multi-cycle hardware clear and a busy flag. Optional macro:
// CACHE_RAM_WRITE_BYPASS_EN (write-first same-address read). Rev 1.0
// ============================================================================
`default_nettype none

module cache_data_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Clear,
  input  logic              readEn,
  input  logic [ADDR_W-1:0] readAddress,
  output logic [DATA_W-1:0] ReadData,
  output logic              readValid,
  input  logic              writeEn,
  input  logic [ADDR_W-1:0] writeAddress,
  input  logic [DATA_W-1:0] WriteData,
  output logic              Busy
);

  // Pointer is one bit wider than the address so DEPTH == 2**ADDR_W fits.
  localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] DEPTH_W  = (ADDR_W+1)'(DEPTH);

  typedef enum logic [0:0] {
    CLEARING = 1'b0,
    IDLE     = 1'b1
  } state_t;

  state_t            state;
  logic [ADDR_W:0]   clr_ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              rd_in_range;
  logic              wr_in_range;
  logic              rd_accept;
  logic              wr_accept;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] rd_next;

  assign rd_in_range = {1'b0, readAddress}  < DEPTH_W;
  assign wr_in_range = {1'b0, writeAddress} < DEPTH_W;
  assign rd_accept   = (state == IDLE) && readEn;
  assign wr_accept   = (state == IDLE) && writeEn && wr_in_range;

  // The clear sequencer owns the single write port while it runs.
  assign mem_we    = !Reset && ((state == CLEARING) || wr_accept);
  assign mem_waddr = (state == CLEARING) ? clr_ptr[ADDR_W-1:0] : writeAddress;
  assign mem_wdata = (state == CLEARING) ? '0 : WriteData;

  always_comb begin
    rd_next = '0;
    if (rd_in_range) begin
      rd_next = mem[readAddress];
`ifdef CACHE_RAM_WRITE_BYPASS_EN
      if (wr_accept && (writeAddress == readAddress)) begin
        rd_next = WriteData;
      end
`endif
    end
  end

  always_ff @(posedge Clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= CLEARING;
      clr_ptr   <= '0;
      Busy      <= 1'b1;
      readValid <= 1'b0;
      ReadData  <= '0;
    end else begin
      readValid <= rd_accept;
      if (rd_accept) begin
        ReadData <= rd_next;
      end
      case (state)
        CLEARING: begin
          if (clr_ptr == LAST_PTR) begin
            state   <= IDLE;
            Busy    <= 1'b0;
            clr_ptr <= '0;
          end else begin
            clr_ptr <= clr_ptr + 1'b1;
          end
        end
        IDLE: begin
          if (Clear) begin
            state   <= CLEARING;
            Busy    <= 1'b1;
            clr_ptr <= '0;
          end
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cache_data_ram.sv
// ============================================================================
// tb_cache_data_ram: directed self-checking bench for cache_data_ram
// (64-word and 40-word instances). Rev 1.0
// ============================================================================
`default_nettype none

module tb_cache_data_ram;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       s_reset = 1'b1;
  logic       Clear = 1'b0;
  logic       readEn = 1'b0;
  logic [5:0] readAddress = '0;
  logic       writeEn = 1'b0;
  logic [5:0] writeAddress = '0;
  logic [7:0] WriteData = '0;

  logic [7:0] ReadData, s_rdata;
  logic       readValid, s_valid;
  logic       Busy, s_busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 Clk = ~Clk;

  cache_data_ram #(.DATA_W(8), .ADDR_W(6), .DEPTH(64)) dut (
    .Clk(Clk), .Reset(Reset), .Clear(Clear),
    .readEn(readEn), .readAddress(readAddress),
    .ReadData(ReadData), .readValid(readValid),
    .writeEn(writeEn), .writeAddress(writeAddress), .WriteData(WriteData),
    .Busy(Busy)
  );

  cache_data_ram #(.DATA_W(8), .ADDR_W(6), .DEPTH(40)) dut_small (
    .Clk(Clk), .Reset(s_reset), .Clear(Clear),
    .readEn(readEn), .readAddress(readAddress),
    .ReadData(s_rdata), .readValid(s_valid),
    .writeEn(writeEn), .writeAddress(writeAddress), .WriteData(WriteData),
    .Busy(s_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic wr(input logic [5:0] a, input logic [7:0] d);
    writeEn = 1'b1; writeAddress = a; WriteData = d;
    tick();
    writeEn = 1'b0;
  endtask

  task automatic rd(input string tag, input bit sel, input logic [5:0] a, input logic [7:0] exp);
    readEn = 1'b1; readAddress = a;
    tick();
    readEn = 1'b0;
    check({tag, "_valid"}, sel ? s_valid : readValid, 1);
    check({tag, "_data"},  sel ? s_rdata : ReadData, exp);
  endtask

  task automatic count_busy(input string tag, input bit sel, input int exp);
    int cnt = 0;
    do begin
      tick();
      cnt++;
    end while ((sel ? s_busy : Busy) && cnt < 200);
    check(tag, cnt, exp);
  endtask

  initial begin
    logic saw_valid;
    int   cnt;
    logic [7:0] same_exp;

    // Reset state
    tick(); tick();
    check("rst_rdata", ReadData, 0);
    check("rst_valid", readValid, 0);
    check("rst_busy", Busy, 1);
    Reset = 1'b0;
    count_busy("init_clear_len", 0, 64);

    rd("rd0", 0, 6'd0, 8'h00);
    rd("rd31", 0, 6'd31, 8'h00);
    rd("rd63", 0, 6'd63, 8'h00);

    // Writes then back-to-back reads
    wr(6'd5, 8'hA5);
    wr(6'd63, 8'h3C);
    rd("b2b_5", 0, 6'd5, 8'hA5);
    rd("b2b_63", 0, 6'd63, 8'h3C);
    tick();
    check("idle_valid", readValid, 0);
    check("idle_hold", ReadData, 8'h3C);

    // Clear with blocked requests
    wr(6'd7, 8'h11);
    rd("pre_clr7", 0, 6'd7, 8'h11);
    Clear = 1'b1;
    tick();
    Clear = 1'b0;
    check("clr_busy_rise", Busy, 1);
    writeEn = 1'b1; writeAddress = 6'd7; WriteData = 8'hFF;
    readEn = 1'b1; readAddress = 6'd7;
    saw_valid = 1'b0;
    cnt = 0;
    while (Busy && cnt < 200) begin
      tick();
      cnt++;
      if (Busy && readValid) saw_valid = 1'b1;
    end
    writeEn = 1'b0; readEn = 1'b0;
    check("clr_len", cnt, 64);
    check("valid_during_busy", saw_valid, 0);
    check("rdata_held_busy", ReadData, 8'h11);
    rd("post_clr7", 0, 6'd7, 8'h00);
    rd("post_clr5", 0, 6'd5, 8'h00);

    // Reset in the middle of a clear
    wr(6'd3, 8'h5A);
    rd("pre_abort3", 0, 6'd3, 8'h5A);
    Clear = 1'b1;
    tick();
    Clear = 1'b0;
    repeat (10) tick();
    Reset = 1'b1;
    #1;
    check("abort_rdata", ReadData, 0);
    check("abort_valid", readValid, 0);
    check("abort_busy", Busy, 1);
    tick();
    Reset = 1'b0;
    count_busy("abort_clear_len", 0, 64);

    // Same-address read during write
    wr(6'd9, 8'h22);
`ifdef CACHE_RAM_WRITE_BYPASS_EN
    same_exp = 8'h99;
`else
    same_exp = 8'h22;
`endif
    writeEn = 1'b1; writeAddress = 6'd9; WriteData = 8'h99;
    rd("rdw_same", 0, 6'd9, same_exp);
    writeEn = 1'b0;
    rd("rdw_after", 0, 6'd9, 8'h99);

    // Different-address read and write together
    writeEn = 1'b1; writeAddress = 6'd10; WriteData = 8'h44;
    rd("rdw_diff", 0, 6'd9, 8'h99);
    writeEn = 1'b0;
    rd("rdw_diff_wr", 0, 6'd10, 8'h44);

    // 40-word instance: shorter clear, out-of-range handling
    Reset = 1'b1;
    s_reset = 1'b0;
    count_busy("small_clear_len", 1, 40);
    wr(6'd45, 8'h77);
    rd("small_oor45", 1, 6'd45, 8'h00);
    wr(6'd39, 8'h6B);
    rd("small_top39", 1, 6'd39, 8'h6B);
    wr(6'd5, 8'h01);
    rd("small_alias5", 1, 6'd5, 8'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
